// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: 2-bit counter branch predictor with outstanding-prediction FIFO and mispredict flush sequencer
// Ports: clk, rst_n (async, active-low); br_valid/br_pc/br_type from decode;
//   pred_taken, stall to decode; pred_type/last_pred (FIFO head) to checker;
//   chk_valid/chk_incorrect/chk_correct from checker; flush, err_underflow (sticky).
// Optional: PRED_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module branch_pred_ctrl #(
  parameter int PC_W      = 12,
  parameter int IDX_W     = 4,
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_pc,
  input  logic [1:0]      br_type,
  output logic            pred_taken,
  output logic            stall,
  output logic [1:0]      pred_type,
  output logic            last_pred,
  input  logic            chk_valid,
  input  logic            chk_incorrect,
  input  logic            chk_correct,
  output logic            flush,
  output logic            err_underflow
`ifdef PRED_STATS_EN
  ,
  output logic [15:0]     hit_cnt,
  output logic [15:0]     miss_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FC_W  = $clog2(FLUSH_CYC + 1);
  localparam int NCNT  = 2 ** IDX_W;
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t state, state_nxt;
  logic [1:0] cnt [NCNT];
  logic [IDX_W-1:0] f_idx [DEPTH];
  logic [1:0] f_type [DEPTH];
  logic f_pred [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [FC_W-1:0] fcnt;
  logic [IDX_W-1:0] idx, h_idx;
  logic [1:0] h_cnt, cnt_upd;
  logic empty, full, push, pop, mispred;
  logic unused_pc;
  assign unused_pc = ^br_pc[PC_W-1:IDX_W];
  assign idx = br_pc[IDX_W-1:0];
  assign empty = count == '0;
  assign full = count == CNT_W'(DEPTH);
  assign pred_taken = cnt[idx][1];
  assign flush = state == FLUSH;
  assign stall = full | flush;
  assign push = br_valid & (|br_type) & ~stall;
  assign pop = (state == IDLE) & chk_valid & ~empty;
  assign mispred = pop & chk_incorrect;
  assign h_idx = f_idx[rd_ptr];
  assign h_cnt = cnt[h_idx];
  assign cnt_upd = chk_correct ? (&h_cnt ? h_cnt : h_cnt + 2'd1) : (|h_cnt ? h_cnt - 2'd1 : h_cnt);
  assign pred_type = empty ? 2'b00 : f_type[rd_ptr];
  assign last_pred = ~empty & f_pred[rd_ptr];
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (mispred ? FLUSH : IDLE) : (fcnt == '0 ? IDLE : FLUSH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fcnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      err_underflow <= 1'b0;
      for (int i = 0; i < NCNT; i++) cnt[i] <= 2'b01;
    end else begin
      state <= state_nxt;
      fcnt <= mispred ? FC_W'(FLUSH_CYC - 1) : (fcnt != '0 ? fcnt - 1'b1 : fcnt);
      if (pop) cnt[h_idx] <= cnt_upd;
      if (state == IDLE && chk_valid && empty) err_underflow <= 1'b1;
      // a mispredict makes every younger entry wrong-path, including a same-cycle push
      if (mispred) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      f_idx[wr_ptr] <= idx;
      f_type[wr_ptr] <= br_type;
      f_pred[wr_ptr] <= pred_taken;
    end
  end
`ifdef PRED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else if (pop) begin
      if (chk_incorrect && ~&miss_cnt) miss_cnt <= miss_cnt + 16'd1;
      if (!chk_incorrect && ~&hit_cnt) hit_cnt <= hit_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: directed vector table, corner sequences and randomized model check for branch_pred_ctrl
module tb_branch_pred_ctrl;
  localparam int DEPTH = 4;
  localparam int FLUSH_CYC = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic br_valid = 1'b0, chk_valid = 1'b0, chk_incorrect = 1'b0, chk_correct = 1'b0;
  logic [11:0] br_pc = '0;
  logic [1:0] br_type = '0;
  logic pred_taken, stall, last_pred, flush, err_underflow;
  logic [1:0] pred_type;
`ifdef PRED_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif
  always #5 clk = ~clk;
  branch_pred_ctrl dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_pc(br_pc), .br_type(br_type),
    .pred_taken(pred_taken), .stall(stall), .pred_type(pred_type), .last_pred(last_pred),
    .chk_valid(chk_valid), .chk_incorrect(chk_incorrect), .chk_correct(chk_correct),
    .flush(flush), .err_underflow(err_underflow)
`ifdef PRED_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );
  int n_chk = 0, n_fail = 0;
  typedef struct {int idx; int t; bit p;} ent_t;
  ent_t q[$];
  int tbl[16];
  int fl_left, m_hit, m_miss;
  bit m_err;
  typedef struct {int bv, pc, bt, cv, ci, cc, ep, es, et, el, ef, ee;} vec_t;
  vec_t vt[22];
  task automatic chk(input string name, input logic [15:0] act, input int exp);
    n_chk++;
    if (act !== 16'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    foreach (tbl[i]) tbl[i] = 1;
    fl_left = 0;
    m_err = 0;
    m_hit = 0;
    m_miss = 0;
  endtask
  task automatic model_check();
    chk("pred_taken", 16'(pred_taken), int'(tbl[int'(br_pc[3:0])] >= 2));
    chk("stall", 16'(stall), int'(q.size() == DEPTH || fl_left > 0));
    chk("pred_type", 16'(pred_type), q.size() > 0 ? q[0].t : 0);
    chk("last_pred", 16'(last_pred), q.size() > 0 ? int'(q[0].p) : 0);
    chk("flush", 16'(flush), int'(fl_left > 0));
    chk("err_underflow", 16'(err_underflow), int'(m_err));
`ifdef PRED_STATS_EN
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
`endif
  endtask
  task automatic model_update();
    bit push, p0;
    int i;
    p0 = tbl[int'(br_pc[3:0])] >= 2;
    if (fl_left > 0) fl_left--;
    else begin
      push = br_valid && br_type != 0 && q.size() < DEPTH;
      if (chk_valid && q.size() == 0) m_err = 1;
      if (chk_valid && q.size() > 0) begin
        i = q[0].idx;
        tbl[i] = chk_correct ? (tbl[i] < 3 ? tbl[i] + 1 : 3) : (tbl[i] > 0 ? tbl[i] - 1 : 0);
        if (chk_incorrect) begin
          q.delete();
          fl_left = FLUSH_CYC;
          push = 0;
          if (m_miss < 65535) m_miss++;
        end else begin
          void'(q.pop_front());
          if (m_hit < 65535) m_hit++;
        end
      end
      if (push) q.push_back('{int'(br_pc[3:0]), int'(br_type), p0});
    end
  endtask
  task automatic drive(input int bv, input int pc, input int bt, input int cv, input int ci, input int cc);
    @(negedge clk);
    br_valid = bv[0];
    br_pc = pc[11:0];
    br_type = bt[1:0];
    chk_valid = cv[0];
    chk_incorrect = ci[0];
    chk_correct = cc[0];
    #1;
    model_check();
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
  endtask
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    br_valid = 1'b0;
    chk_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    vt[0]  = '{1, 'h005, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 'h005, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[2]  = '{0, 'h005, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0};
    vt[3]  = '{0, 'h005, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    vt[4]  = '{0, 'h005, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0};
    vt[5]  = '{1, 'h005, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vt[6]  = '{0, 'h005, 0, 1, 0, 1, 1, 0, 2, 1, 0, 0};
    vt[7]  = '{1, 'h005, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vt[8]  = '{0, 'h005, 0, 1, 0, 1, 1, 0, 3, 1, 0, 0};
    vt[9]  = '{1, 'h001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[10] = '{1, 'h002, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[11] = '{1, 'h003, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[12] = '{1, 'h004, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[13] = '{1, 'h006, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    vt[14] = '{0, 'h006, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    vt[15] = '{0, 'h002, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[16] = '{0, 'h002, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0};
    vt[17] = '{0, 'h002, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0};
    vt[18] = '{0, 'h002, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0};
    vt[19] = '{0, 'h002, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vt[20] = '{0, 'h002, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
    vt[21] = '{0, 'h002, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    model_reset();
    reset_dut();
    foreach (vt[i]) begin
      drive(vt[i].bv, vt[i].pc, vt[i].bt, vt[i].cv, vt[i].ci, vt[i].cc);
      chk($sformatf("vec%0d.pred_taken", i), 16'(pred_taken), vt[i].ep);
      chk($sformatf("vec%0d.stall", i), 16'(stall), vt[i].es);
      chk($sformatf("vec%0d.pred_type", i), 16'(pred_type), vt[i].et);
      chk($sformatf("vec%0d.last_pred", i), 16'(last_pred), vt[i].el);
      chk($sformatf("vec%0d.flush", i), 16'(flush), vt[i].ef);
      chk($sformatf("vec%0d.err_underflow", i), 16'(err_underflow), vt[i].ee);
      tick();
    end
    reset_dut();
    drive(1, 'h007, 1, 0, 0, 0);
    chk("err_cleared_by_reset", 16'(err_underflow), 0);
    tick();
    drive(0, 'h007, 0, 1, 1, 0);
    tick();
    drive(0, 'h005, 0, 0, 0, 0);
    chk("flush_before_reset", 16'(flush), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_flush", 16'(flush), 0);
    chk("async_reset_stall", 16'(stall), 0);
    chk("async_reset_pred_type", 16'(pred_type), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 'h005, 0, 0, 0, 0);
    chk("table_reset_pc5", 16'(pred_taken), 0);
    tick();
`ifdef PRED_STATS_EN
    reset_dut();
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 1, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 1);
      tick();
    end
    drive(0, 0, 0, 1, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("stats_hit", hit_cnt, 3);
    chk("stats_miss", miss_cnt, 1);
    tick();
`endif
    reset_dut();
    repeat (3000) begin
      drive(int'($urandom_range(0, 9) < 6), int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 9) < 4), int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 1)));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
